data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 4: number of store-buffer entries; power of two, 2 to 8.
REQ-002 Parameter AW, default 6: word-address width; RAM holds 2^AW 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemWriteM  input  1  store request this cycle.
REQ-006 ALUOutM  input  32  byte address; word index = ALUOutM[AW+1:2]; bits [1:0] and above AW+1 are ignored.
REQ-007 WriteDataM  input  32  store data.
REQ-008 ReadDataM  output  32  load data, combinational from current ALUOutM.
REQ-009 BufCount  output  $clog2(DEPTH)+1  number of valid store-buffer entries.
REQ-010 BufFull  output  1  BufCount == DEPTH.
REQ-011 DrainValid  output  1  a buffered entry is committed to RAM at this clock edge.

Function
REQ-012 Stores SHALL be posted: the block SHALL never stall the requester, and every store SHALL be accepted in the cycle presented.
REQ-013 The store buffer SHALL be a FIFO of {word index, data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-014 Drain rule: when BufCount>0 and MemWriteM=0, the head entry SHALL be written to RAM at the edge, and head and count SHALL advance.
REQ-015 When MemWriteM=1 and the buffer is not full, the new store SHALL be enqueued at tail and no drain SHALL occur.
REQ-016 When MemWriteM=1 and BufFull=1, the head entry SHALL drain and the new store SHALL enqueue at the same edge; BufCount stays DEPTH.
REQ-017 DrainValid SHALL be combinational and equal (BufCount>0)&&(!MemWriteM || BufFull).
REQ-018 BufCount after the edge SHALL equal count + enqueue - drain; it SHALL never exceed DEPTH or underflow.
REQ-019 ReadDataM SHALL return the data of the youngest valid buffer entry whose word index matches; otherwise the RAM word.
REQ-020 A store in the same cycle SHALL NOT be forwarded: ReadDataM reflects state before the current edge.
REQ-021 Multiple buffer entries to the same index SHALL all be kept; drain order is program order, so the RAM ends holding the youngest value.
REQ-022 An entry draining this cycle SHALL still be forwarded this cycle (state before edge).
REQ-023 RAM SHALL have one synchronous write port, used only by the drain, and one asynchronous read port.

Reset
REQ-024 Reset asserted SHALL immediately clear all entry valid bits and set head=tail=0, BufCount=0, BufFull=0, DrainValid=0.
REQ-025 Buffered stores not yet drained when reset asserts SHALL be discarded; RAM contents SHALL be unaffected by reset.
REQ-026 ReadDataM during reset SHALL be the RAM word at the current address.
REQ-027 MemWriteM SHALL be ignored while reset is high; the first enqueue occurs at the first edge after reset deassertion.

Verification
REQ-028 Setup: reset; then store 0x11111111 to 0x10 and idle two cycles -> BufCount 1 then 0, with DrainValid=1 in the first idle cycle; load 0x10 returns 0x11111111 from RAM.
REQ-029 Forwarding: store 0xAAAA0001 to 0x20, then 0xAAAA0002 to 0x20 in back-to-back cycles; the next cycle is a load of 0x20 -> returns 0xAAAA0002 with BufCount=2; after drain, RAM[8] is 0xAAAA0002.
REQ-030 Full: 6 consecutive stores (data 1..6) to 0x00,0x04,...,0x14 with DEPTH=4 -> BufCount saturates at 4, and DrainValid=1 on stores 5 and 6; after idling, every address reads back its own data.
REQ-031 Same-cycle: store 0x5 to 0x30 while ALUOutM=0x30 with an old value of 0x9 -> ReadDataM=0x9 that cycle and 0x5 the next cycle.
REQ-032 Reset mid-operation: three stores buffered, assert reset asynchronously between edges -> BufCount=0 immediately; loads of those addresses return the pre-store RAM values.
REQ-033 Wrap: 20 alternating store/idle pairs to distinct addresses -> pointers wrap, BufCount alternates 1/0, and all 20 words read back correctly.

Source files
------------

// File: rtl/data_mem_resp.sv
// Data memory with a posted-store buffer.
// Stores enter a FIFO of {word index, data} entries and are committed to a
// 32-bit word RAM when the pipeline is not storing, or when the buffer is
// full and a new store must make room. Loads see the youngest buffered
// value for their word, otherwise the RAM word, all combinationally.
module data_mem_resp #(
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWriteM,
  input  logic [31:0]              ALUOutM,
  input  logic [31:0]              WriteDataM,
  output logic [31:0]              ReadDataM,
  output logic [$clog2(DEPTH):0]   BufCount,
  output logic                     BufFull,
  output logic                     DrainValid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: there is none toward the requester. A store is accepted in
  // the cycle MemWriteM is high, always. DrainValid marks the edge at which
  // the head entry is written into the RAM.

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_idx  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [31:0]      mem      [0:(1 << AW) - 1];

  logic [AW-1:0]    word_idx;
  logic             full;
  logic             drain;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PW-1:0]    slot;
  logic             unused_addr_bits;

  assign word_idx         = ALUOutM[AW+1:2];
  assign unused_addr_bits = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};

  assign full       = (count == CW'(DEPTH));
  // A full buffer drains on a store so the new entry always has a slot.
  assign drain      = (count != '0) && (!MemWriteM || full);

  assign BufCount   = count;
  assign BufFull    = full;
  assign DrainValid = drain;

  // Buffer bookkeeping: pointers, valid bits and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      // When full, head == tail: the set below overrides the clear above.
      if (MemWriteM) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      count <= count + CW'(MemWriteM) - CW'(drain);
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (MemWriteM) begin
      ent_idx[tail]  <= word_idx;
      ent_data[tail] <= WriteDataM;
    end
  end

  // RAM write port, owned by the drain; contents survive reset.
  always_ff @(posedge clk) begin
    if (drain) begin
      mem[ent_idx[head]] <= ent_data[head];
    end
  end

  // Forwarding search from oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (ent_valid[slot] && (ent_idx[slot] == word_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[slot];
      end
    end
  end

  // Load path: buffered value first, RAM word otherwise.
  always_comb begin
    ReadDataM = fwd_hit ? fwd_data : mem[word_idx];
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed scenarios plus random traffic, checked
// against a reference built from a RAM array and a queue of pending stores.
module tb_data_mem_resp;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int CW    = 3;
  localparam int W     = 38;

  logic          clk;
  logic          reset;
  logic          MemWriteM;
  logic [31:0]   ALUOutM;
  logic [31:0]   WriteDataM;
  logic [31:0]   ReadDataM;
  logic [CW-1:0] BufCount;
  logic          BufFull;
  logic          DrainValid;

  data_mem_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .BufCount   (BufCount),
    .BufFull    (BufFull),
    .DrainValid (DrainValid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0]   mem_m   [64];
  bit            known_m [64];
  logic [AW-1:0] pend_idx  [$];
  logic [31:0]   pend_data [$];

  // Expected entry: {read data, read known, count, full, drain}
  logic [W-1:0]  exp_q [$];
  int            checks;
  int            errors;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; expectation reflects state before the edge.
  task automatic drive(bit we, logic [31:0] addr, logic [31:0] data);
    logic [AW-1:0] idx;
    logic [31:0]   rd;
    bit            kn;
    int            n;
    bit            dv;
    @(posedge clk);
    #1;
    MemWriteM  = we;
    ALUOutM    = addr;
    WriteDataM = data;
    idx = addr[AW+1:2];
    rd  = mem_m[idx];
    kn  = known_m[idx];
    for (int i = 0; i < pend_idx.size(); i++) begin
      if (pend_idx[i] == idx) begin
        rd = pend_data[i];
        kn = 1'b1;
      end
    end
    n  = pend_idx.size();
    dv = (n > 0) && (!we || n == DEPTH);
    exp_q.push_back({rd, kn, CW'(n), (n == DEPTH), dv});
    if (dv) begin
      mem_m[pend_idx[0]]   = pend_data[0];
      known_m[pend_idx[0]] = 1'b1;
      void'(pend_idx.pop_front());
      void'(pend_data.pop_front());
    end
    if (we) begin
      pend_idx.push_back(idx);
      pend_data.push_back(data);
    end
  endtask

  task automatic idle(logic [31:0] addr);
    drive(1'b0, addr, $urandom);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[5]) check("read_data", ReadDataM, e[37:6]);
        check("buf_count", 32'(BufCount), 32'(e[4:2]));
        check("buf_full", 32'(BufFull), 32'(e[1]));
        check("drain_valid", 32'(DrainValid), 32'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) known_m[i] = 1'b0;

    // Reset with a store request that must be ignored.
    reset      = 1'b1;
    MemWriteM  = 1'b1;
    ALUOutM    = 32'h0;
    WriteDataM = 32'hdead_beef;
    repeat (2) @(negedge clk);
    check("reset_count", 32'(BufCount), 32'd0);
    check("reset_full", 32'(BufFull), 32'd0);
    check("reset_drain", 32'(DrainValid), 32'd0);
    MemWriteM = 1'b0;
    reset     = 1'b0;

    // Give every RAM word a known value.
    for (int i = 0; i < 64; i++) drive(1'b1, 32'(i * 4), $urandom);
    repeat (6) idle(32'h0);

    // Store then two idles; load back from RAM.
    drive(1'b1, 32'h10, 32'h1111_1111);
    idle(32'h0);
    idle(32'h0);
    idle(32'h10);

    // Back-to-back stores to one word, youngest forwarded.
    drive(1'b1, 32'h20, 32'haaaa_0001);
    drive(1'b1, 32'h20, 32'haaaa_0002);
    idle(32'h20);
    repeat (3) idle(32'h0);
    idle(32'h20);

    // Overfill the buffer.
    for (int i = 0; i < 6; i++) drive(1'b1, 32'(i * 4), 32'(i + 1));
    repeat (6) idle(32'h0);
    for (int i = 0; i < 6; i++) idle(32'(i * 4));

    // Same-cycle store is not forwarded.
    drive(1'b1, 32'h30, 32'h9);
    repeat (3) idle(32'h0);
    drive(1'b1, 32'h30, 32'h5);
    idle(32'h30);
    repeat (2) idle(32'h0);

    // Reset between edges discards buffered stores.
    drive(1'b1, 32'h40, 32'hc0de_0001);
    drive(1'b1, 32'h44, 32'hc0de_0002);
    drive(1'b1, 32'h48, 32'hc0de_0003);
    @(posedge clk);
    #3;
    pend_idx.delete();
    pend_data.delete();
    reset     = 1'b1;
    MemWriteM = 1'b1;
    ALUOutM   = 32'h40;
    #1;
    check("midreset_count", 32'(BufCount), 32'd0);
    check("midreset_drain", 32'(DrainValid), 32'd0);
    check("midreset_read", ReadDataM, mem_m[16]);
    @(posedge clk);
    #1;
    check("midreset_ignore_store", 32'(BufCount), 32'd0);
    @(negedge clk);
    MemWriteM = 1'b0;
    reset     = 1'b0;
    idle(32'h40);
    idle(32'h44);
    idle(32'h48);

    // Store/idle pairs walking the pointers around several times.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(32'h80 + i * 4), $urandom);
      idle(32'h0);
    end
    for (int i = 0; i < 20; i++) idle(32'(32'h80 + i * 4));

    // Random traffic, biased toward a few words to exercise forwarding.
    repeat (400) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[7:2] = 6'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), a, $urandom);
    end
    repeat (6) idle(32'h0);

    // Let the monitor consume the last expectations.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 entries left", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
